// File: rtl/ex_hazard_ctrl.sv
// EX-side pipeline sequencer: redirect flushes, load-use bubbles and multi-cycle op holds.
// Optional performance counters are built only when EX_HAZARD_PERF_EN is defined.
module ex_hazard_ctrl #(
  parameter int MC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifidrs,
  input  logic [4:0]  ifidrt,
  input  logic        idexmemread,
  input  logic [4:0]  idexrd,
  input  logic        idexmc,
  input  logic        exbranch,
  input  logic        idexjump,
  input  logic        idexjr,
  output logic        pcwrite,
  output logic        ifidwrite,
  output logic        ifidflush,
  output logic        idexflush,
  output logic        idexhold,
  output logic        exmbubble,
  output logic        mcbusy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {S_RUN, S_MCBUSY} state_t;

  // Entry cycle and release cycle bracket the held cycles, hence the -2.
  localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 2);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_mc_cnt, w_mc_cnt_nxt;
  logic       w_redirect, w_loaduse;

  assign w_redirect = exbranch | idexjump | idexjr;
  assign w_loaduse  = idexmemread && (idexrd != 5'd0) &&
                      ((idexrd == ifidrs) || (idexrd == ifidrt));

  always_comb begin
    pcwrite      = 1'b1;
    ifidwrite    = 1'b1;
    ifidflush    = 1'b0;
    idexflush    = 1'b0;
    idexhold     = 1'b0;
    exmbubble    = 1'b0;
    mcbusy       = 1'b0;
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          if (w_redirect) begin
            ifidflush = 1'b1;
            idexflush = 1'b1;
          end else if (idexmc) begin
            pcwrite      = 1'b0;
            ifidwrite    = 1'b0;
            idexhold     = 1'b1;
            exmbubble    = 1'b1;
            w_state_nxt  = S_MCBUSY;
            w_mc_cnt_nxt = MC_LOAD;
          end else if (w_loaduse) begin
            pcwrite   = 1'b0;
            ifidwrite = 1'b0;
            idexflush = 1'b1;
          end
        end
        S_MCBUSY: begin
          mcbusy = 1'b1;
          if (r_mc_cnt != 4'd0) begin
            pcwrite      = 1'b0;
            ifidwrite    = 1'b0;
            idexhold     = 1'b1;
            exmbubble    = 1'b1;
            w_mc_cnt_nxt = r_mc_cnt - 4'd1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_mc_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

`ifdef EX_HAZARD_PERF_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        w_flush_evt;

  assign w_flush_evt = (r_state == S_RUN) && w_redirect && !rst;

  // Counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      if (!pcwrite && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_evt && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule
